// File: rtl/prod_batch_acc_if.sv
// Product-stream input and batch-sum output bundle for prod_batch_acc.
// out_max is present only when PROD_BATCH_ACC_MAX_EN is defined.
interface prod_batch_acc_if #(
   parameter int unsigned W = 4
);
   localparam int unsigned SW = 2 * W + 4;

   logic [2*W-1:0] prod;
   logic           in_vld;
   logic           in_rdy;
   logic           clr;
   logic [SW-1:0]  out_sum;
   logic           out_vld;
   logic           out_rdy;
   logic [3:0]     cnt;
`ifdef PROD_BATCH_ACC_MAX_EN
   logic [2*W-1:0] out_max;

   modport master (
      output prod, in_vld, clr, out_rdy,
      input  in_rdy, out_sum, out_vld, cnt, out_max
   );
   modport slave (
      input  prod, in_vld, clr, out_rdy,
      output in_rdy, out_sum, out_vld, cnt, out_max
   );
`else
   modport master (
      output prod, in_vld, clr, out_rdy,
      input  in_rdy, out_sum, out_vld, cnt
   );
   modport slave (
      input  prod, in_vld, clr, out_rdy,
      output in_rdy, out_sum, out_vld, cnt
   );
`endif
endinterface

// File: rtl/prod_batch_acc.sv
// Sums batches of N accepted products and holds each sum until taken downstream.
// Define PROD_BATCH_ACC_MAX_EN to also report the per-batch maximum product on out_max.
module prod_batch_acc #(
   parameter int unsigned W = 4,
   parameter int unsigned N = 4
) (
   input logic             clk,
   input logic             rst_b,
   prod_batch_acc_if.slave bus
);
   localparam int unsigned SW = 2 * W + 4;
   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;
   localparam logic [3:0] CNT_LAST = 4'(N - 1);

   logic [0:0]    state_q, state_d;
   logic [SW-1:0] sum_q, sum_d;
   logic [SW-1:0] out_sum_q, out_sum_d;
   logic [SW-1:0] sum_inc;
   logic [3:0]    cnt_q, cnt_d;

   assign sum_inc = sum_q + SW'(bus.prod);

   // clr outranks both the accept and the out handshake
   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      out_sum_d = out_sum_q;
      if (bus.clr) begin
         state_d = ST_ACC;
         sum_d   = '0;
         cnt_d   = '0;
      end else if (state_q == ST_HOLD) begin
         if (bus.out_rdy) state_d = ST_ACC;
      end else if (bus.in_vld) begin
         if (cnt_q == CNT_LAST) begin
            out_sum_d = sum_inc;
            sum_d     = '0;
            cnt_d     = '0;
            state_d   = ST_HOLD;
         end else begin
            sum_d = sum_inc;
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_ACC;
         sum_q     <= '0;
         cnt_q     <= '0;
         out_sum_q <= '0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         out_sum_q <= out_sum_d;
      end
   end

   assign bus.in_rdy  = (state_q == ST_ACC);
   assign bus.out_vld = (state_q == ST_HOLD);
   assign bus.out_sum = out_sum_q;
   assign bus.cnt     = cnt_q;

`ifdef PROD_BATCH_ACC_MAX_EN
   logic [2*W-1:0] max_q, max_d;
   logic [2*W-1:0] out_max_q, out_max_d;
   logic [2*W-1:0] max_new;

   assign max_new = (bus.prod > max_q) ? bus.prod : max_q;

   always_comb begin
      max_d     = max_q;
      out_max_d = out_max_q;
      if (bus.clr) begin
         max_d = '0;
      end else if ((state_q == ST_ACC) && bus.in_vld) begin
         if (cnt_q == CNT_LAST) begin
            out_max_d = max_new;
            max_d     = '0;
         end else begin
            max_d = max_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         max_q     <= '0;
         out_max_q <= '0;
      end else begin
         max_q     <= max_d;
         out_max_q <= out_max_d;
      end
   end

   assign bus.out_max = out_max_q;
`endif
endmodule

// File: doc/prod_batch_acc.md
Name: prod_batch_acc

Overview:
- Downstream consumer of the last-two-values multiplier stage.
- Takes its 2*W-bit product stream under a valid/ready handshake and sums batches of N consecutive accepted products.
- Presents each batch sum on a held output with its own valid/ready handshake.
- Used to build windowed energy/score values from the multiplier output.

Parameters:
W, 4, input operand width of the upstream multiplier; the product input is 2*W bits.
N, 4, products per batch; legal range 2..16.
SW, 2*W+4, sum width; derived, not overridden. Holds 16 maximal products without overflow.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_b  input  1  asynchronous reset, active-low
prod  input  2*W  product from upstream multiplier
in_vld  input  1  prod valid
in_rdy  output  1  block can accept prod this cycle
clr  input  1  synchronous clear of the partial batch, active-high
out_sum  output  SW  completed batch sum
out_vld  output  1  out_sum valid
out_rdy  input  1  downstream accepts out_sum
cnt  output  4  number of products accepted in the current batch, 0..N-1

Behaviour:
- Reset (rst_b=0, asynchronous, takes effect immediately):
  - state=ACC; internal sum=0; cnt=0; out_sum=0; out_vld=0.
  - Reset held mid-batch or mid-HOLD discards everything.
- FSM states:
  - ACC: in_rdy=1, out_vld=0.
  - HOLD: in_rdy=0, out_vld=1.
  - in_rdy is a combinational decode of state only; it never depends on in_vld.
- ACC, accept (in_vld=1 at rising edge):
  - If cnt<N-1: sum<=sum+prod, zero-extended to SW; cnt<=cnt+1.
  - If cnt==N-1: out_sum<=sum+prod; out_vld<=1; sum<=0; cnt<=0; go to HOLD.
  - Latency: out_vld rises on the same edge that accepts the N-th product.
- ACC, no accept (in_vld=0): no change.
- HOLD:
  - out_sum and out_vld are held stable; in_vld and prod are ignored.
  - On a rising edge with out_rdy=1: out_vld<=0 and go to ACC.
  - out_sum keeps its last value after the handshake, only out_vld drops.
  - The first product of the next batch is accepted no earlier than the edge after the out handshake.
- clr=1 at a rising edge, highest priority after reset:
  - sum<=0; cnt<=0; out_vld<=0; state<=ACC; out_sum unchanged.
  - Overrides a simultaneous accept or out handshake. A batch completing on that edge is discarded.
- Arithmetic:
  - Unsigned only; no saturation is needed with N<=16.
  - out_sum bits above the true sum width are always 0.
- Simultaneous events:
  - in_vld=1 with out_rdy=1 in ACC: out_rdy is ignored; only the accept happens.
  - in_vld=1 with out_rdy=1 in HOLD: only the out handshake happens.

Optional Feature:
- Macro PROD_BATCH_ACC_MAX_EN.
- When defined:
  - Adds output out_max [2*W-1:0], the maximum product accepted in the batch.
  - Tracked with a running max register that is cleared to 0 on reset, clr and batch completion.
  - out_max is latched together with out_sum on the completing edge and held in HOLD.
- When undefined:
  - Port and register are absent; all other behaviour is identical.

Test Plan:
- W=4,N=4: accept prod 50,25,10,65 on 4 consecutive edges -> out_vld=1 on the 4th edge, out_sum=150, cnt=0, in_rdy=0. With MAX_EN: out_max=65.
- In HOLD, out_rdy=0 for 3 cycles while in_vld=1 with prod=99 -> out_sum stays 150, cnt stays 0. out_rdy=1 -> out_vld=0 next edge, in_rdy=1. The next batch starts from 0 and excludes 99.
- Four prods of 225 (W=4 maximum), then four of 0 -> first out_sum=900, second out_sum=0. N=16 with all 225 -> out_sum=3600, no wrap.
- Accept 10,13; assert clr with in_vld=1, prod=7 -> cnt=0, sum discarded. Then 1,2,3,4 -> out_sum=10.
- Accept 10,13,15, then drop rst_b between edges -> out_vld=0, out_sum=0, cnt=0 immediately. After release, 1,1,1,1 -> out_sum=4.
- W=6,N=2: prods 3969,819 -> out_sum=4788 on the 2nd accept edge. Gaps of in_vld=0 between accepts leave cnt and sum unchanged.
